// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - elastic valid/ready pipeline register stage with flush and bubble-zeroed control
//
// Purpose: STAGES register slots in series between two pipeline stages.
// Beats advance whenever the slot ahead is empty or itself advancing, so
// bubbles collapse under backpressure. A full, flowing stage still passes
// one beat per cycle. The control field always reads zero for a bubble, so
// write enables never leak downstream.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high clear of all state
//   flush      synchronous kill of all slots and of the current input beat
//   in_valid   upstream offers a beat
//   in_ready   stage accepts a beat this cycle
//   in_ctrl    control field of the offered beat
//   in_data    data field of the offered beat
//   out_valid  output slot holds a live beat (masked by flush)
//   out_ready  downstream accepts this cycle
//   out_ctrl   control field of the output slot, zero when it is a bubble
//   out_data   data field of the output slot (holds when invalid)
//   count      number of valid slots

module pipe_stage_hs #(
  parameter  int CTRL_W = 4,
  parameter  int DATA_W = 101,
  parameter  int STAGES = 1,
  localparam int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  count
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] take;
  logic [CTRL_W-1:0] ctrl_q   [STAGES];
  logic [CTRL_W-1:0] ctrl_nxt [STAGES];
  logic [DATA_W-1:0] data_q   [STAGES];
  logic [DATA_W-1:0] data_nxt [STAGES];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;

  // A slot may load when it is empty or when the slot ahead is also loading;
  // this ripples from the output side back to the input.
  always_comb begin
    take = '0;
    take[STAGES-1] = !v_q[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      take[i] = !v_q[i] | take[i+1];
    end
  end

  always_comb begin
    v_nxt    = v_q;
    ctrl_nxt = ctrl_q;
    data_nxt = data_q;
    if (flush) begin
      // Data is deliberately held; only validity and control are killed.
      v_nxt = '0;
      for (int i = 0; i < STAGES; i++) begin
        ctrl_nxt[i] = '0;
      end
    end else begin
      if (take[0]) begin
        v_nxt[0]    = in_valid;
        ctrl_nxt[0] = in_valid ? in_ctrl : '0;
        data_nxt[0] = in_data;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (take[i]) begin
          v_nxt[i]    = v_q[i-1];
          ctrl_nxt[i] = v_q[i-1] ? ctrl_q[i-1] : '0;
          data_nxt[i] = data_q[i-1];
        end
      end
    end
    // Occupancy is registered with the valid bits so count has no comb path.
    count_nxt = '0;
    for (int i = 0; i < STAGES; i++) begin
      count_nxt = count_nxt + CNT_W'(v_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      v_q      <= v_nxt;
      ctrl_q   <= ctrl_nxt;
      data_q   <= data_nxt;
      count_q  <= count_nxt;
    end
  end

  // Flush always accepts (and drops) the offered beat and hides the output beat.
  assign in_ready  = take[0] | flush;
  assign out_valid = v_q[STAGES-1] & !flush;
  assign out_ctrl  = v_q[STAGES-1] ? ctrl_q[STAGES-1] : '0;
  assign out_data  = data_q[STAGES-1];
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb/tb_pipe_stage_hs.sv - scoreboard bench for pipe_stage_hs with beat-age reference model
module tb_pipe_stage_hs;

  localparam int S    = 3;
  localparam int CW   = 4;
  localparam int DW   = 101;
  localparam int CNTW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [CNTW-1:0] count;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  bit mon_en = 1'b0;

  // Each in-flight beat remembers the edge at which it was accepted; the head
  // beat reaches the output once it has been inside for S-1 further edges.
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    int            a;
  } beat_t;
  beat_t q[$];
  beat_t mb;
  bit    exp_ov;

  pipe_stage_hs #(.CTRL_W(CW), .DATA_W(DW), .STAGES(S)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // One clock of stimulus; the accepted beat is recorded for the scoreboard.
  task automatic cycle(input bit iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input bit ordy, input bit fl);
    beat_t b;
    bit    acc;
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_ctrl   = ic;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    acc = in_valid && in_ready && !flush;
    b.c = in_ctrl;
    b.d = in_data;
    b.a = edge_cnt + 1;
    #2;
    if (fl) q.delete();
    else if (acc) q.push_back(b);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  // Monitor: compares the DUT against the model once per cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        exp_ov = !flush && (q.size() > 0) && ((edge_cnt - q[0].a) >= S - 1);
        chk("count", 128'(count), 128'(q.size()));
        chk("in_ready", 128'(in_ready), 128'(flush || (q.size() < S) || out_ready));
        chk("out_valid", 128'(out_valid), 128'(exp_ov));
        if (!out_valid && !flush) chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none t=%0t", out_data, $time);
          end else begin
            mb = q.pop_front();
            chk("out_data", 128'(out_data), 128'(mb.d));
            chk("out_ctrl", 128'(out_ctrl), 128'(mb.c));
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    // Streaming: 10 back-to-back beats with a free-running sink.
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'hF, DW'(i), 1'b1, 1'b0);
    drain(6);

    // Backpressure: fill, get refused, then one beat leaves as another enters.
    for (int i = 0; i < S + 1; i++) cycle(1'b1, 4'h5, DW'(100 + i), 1'b0, 1'b0);
    cycle(1'b1, 4'h5, DW'(100 + S), 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_full_count", 128'(count), 128'(S));
    drain(6);

    // Bubbles carrying a nonzero control field must never show it.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'hF, rnd_data(), 1'b1, 1'b0);

    // Flush with beats held and a beat offered in the same cycle.
    cycle(1'b1, 4'h3, DW'(200), 1'b0, 1'b0);
    cycle(1'b1, 4'h3, DW'(201), 1'b0, 1'b0);
    cycle(1'b1, 4'hA, DW'(202), 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_ctrl", 128'(out_ctrl), 128'(0));
    drain(4);

    // Asynchronous reset while full, between clock edges.
    for (int i = 0; i < S; i++) cycle(1'b1, 4'h7, DW'(300 + i), 1'b0, 1'b0);
    mon_en   = 1'b0;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("mid_rst_count", 128'(count), 128'(0));
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 9) < 7, CW'($urandom), rnd_data(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
    end
    drain(8);
    chk("final_count", 128'(count), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
